serial_add_sub: RTL and testbench

//   Parametrised bit-serial adder/subtractor: one WIDTH-bit operation per WIDTH+1 clocks.

---
 rtl/serial_arith_pkg.sv | 14 +
 rtl/serial_add_sub_full_adder.sv | 13 +
 rtl/serial_add_sub.sv | 104 ++++++++++
 tb/tb_serial_add_sub.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the add/subtract mode constants.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// One-bit full adder used as the single bit-slice of the serial adder/subtractor.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one WIDTH-bit add or subtract per WIDTH+1 clocks,
// LSB first through a single full-adder cell, with start/busy/done handshake.
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_bit (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  // New result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign acc_next = {fa_sum, acc[WIDTH-1:1]};

  // Subtraction is a + ~b + 1, so the mode only changes what is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= (sub == MODE_SUB) ? ~b : b;
            carry <= (sub == MODE_SUB) ? 1'b1 : cin;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          acc   <= acc_next;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_carry;
          // The carry register still holds the carry into the MSB on the last edge.
          if (cnt == LAST_BIT) begin
            sum   <= acc_next;
            cout  <= fa_carry;
            ovf   <= carry ^ fa_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and randomised checks of serial_add_sub at WIDTH=8 and WIDTH=3,
// comparing results and busy/done timing against a behavioural model.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       start3, sub3, cin3;
  logic [2:0] a3, b3;
  logic       busy3, done3, cout3, ovf3;
  logic [2:0] sum3;

  int checks = 0;
  int passes = 0;

  logic [9:0] last8 = '0;
  logic [4:0] last3 = '0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_add_sub #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .sub(sub3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Golden results packed as {ovf, cout, sum}; overflow from operand/result signs.
  function automatic logic [9:0] model8(input logic s, input logic [7:0] x, y, input logic c);
    logic [7:0] yy;
    logic [8:0] full;
    logic       v;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {8'd0, (s ? 1'b1 : c)};
    v    = (x[7] == yy[7]) && (full[7] != x[7]);
    return {v, full};
  endfunction

  function automatic logic [4:0] model3(input logic s, input logic [2:0] x, y, input logic c);
    logic [2:0] yy;
    logic [3:0] full;
    logic       v;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {3'd0, (s ? 1'b1 : c)};
    v    = (x[2] == yy[2]) && (full[2] != x[2]);
    return {v, full};
  endfunction

  // Called just after a falling edge with the WIDTH=8 unit idle.
  task automatic applyStimulus(input logic s, input logic [7:0] x, y, input logic c,
                               input logic [9:0] expected, input string tag);
    sub = s; a = x; b = y; cin = c; start = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0; a = ~x; b = y ^ 8'h5A; sub = ~s; cin = ~c;
      end
      checkOutput({tag, " busy"}, busy, (i <= 8));
      checkOutput({tag, " done"}, done, (i == 9));
      if (i == 4) checkOutput({tag, " hold"}, {ovf, cout, sum}, last8);
    end
    checkOutput({tag, " result"}, {ovf, cout, sum}, expected);
    last8 = expected;
    @(negedge clk);
    checkOutput({tag, " done drop"}, {busy, done}, 2'b00);
  endtask

  task automatic applyStimulusNarrow(input logic s, input logic [2:0] x, y, input logic c);
    logic [4:0] expected;
    expected = model3(s, x, y, c);
    sub3 = s; a3 = x; b3 = y; cin3 = c; start3 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start3 = 1'b0; a3 = ~x; b3 = ~y; sub3 = ~s;
      end
      checkOutput("w3 busy", busy3, (i <= 3));
      checkOutput("w3 done", done3, (i == 4));
      if (i == 2) checkOutput("w3 hold", {ovf3, cout3, sum3}, last3);
    end
    checkOutput("w3 result", {ovf3, cout3, sum3}, expected);
    last3 = expected;
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] e1, e2;
    int         done_seen;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start3 = 1'b0; sub3 = 1'b0; cin3 = 1'b0; a3 = '0; b3 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset w8", {busy, done, ovf, cout, sum}, '0);
    checkOutput("reset w3", {busy3, done3, ovf3, cout3, sum3}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, {1'b1, 1'b0, 8'h96}, "add 5A+3C");
    applyStimulus(1'b0, 8'hFF, 8'h01, 1'b1, {1'b0, 1'b1, 8'h01}, "add FF+01+1");
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00}, "add 00+00");
    applyStimulus(1'b1, 8'h10, 8'h20, 1'b0, {1'b0, 1'b0, 8'hF0}, "sub 10-20");
    applyStimulus(1'b1, 8'h80, 8'h01, 1'b0, {1'b1, 1'b1, 8'h7F}, "sub 80-01");
    applyStimulus(1'b1, 8'h7F, 8'hFF, 1'b1, {1'b1, 1'b0, 8'h80}, "sub 7F-FF");

    // Back-to-back: start held high, operands scrambled every cycle.
    sub = 1'b0; a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
    e1 = {1'b0, 1'b0, 8'h78};
    e2 = '0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      checkOutput("b2b busy", busy, (k != 9 && k != 18));
      checkOutput("b2b done", done, (k == 9 || k == 18));
      if (k == 9)  checkOutput("b2b first", {ovf, cout, sum}, e1);
      if (k == 18) checkOutput("b2b second", {ovf, cout, sum}, e2);
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      if (k == 9) e2 = model8(sub, a, b, cin);
      if (k == 18) start = 1'b0;
    end
    last8 = e2;
    @(negedge clk);
    checkOutput("b2b idle", {busy, done}, 2'b00);

    // Reset in the middle of an operation.
    applyStimulus(1'b0, 8'h12, 8'h34, 1'b0, {1'b0, 1'b0, 8'h46}, "pre-reset");
    sub = 1'b0; a = 8'hC3; b = 8'h5A; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset", {busy, done, ovf, cout, sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    last8 = '0;
    last3 = '0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checkOutput("no done after reset", done_seen, 0);
    applyStimulus(1'b0, 8'h01, 8'h01, 1'b0, {1'b0, 1'b0, 8'h02}, "add after reset");

    for (int n = 0; n < 1000; n++) begin
      logic       rs, rc;
      logic [7:0] ra, rb;
      rs = 1'($urandom); rc = 1'($urandom); ra = 8'($urandom); rb = 8'($urandom);
      applyStimulus(rs, ra, rb, rc, model8(rs, ra, rb, rc), "rand w8");
    end

    applyStimulusNarrow(1'b0, 3'd3, 3'd1, 1'b0);
    checkOutput("w3 3+1 ovf", {ovf3, cout3, sum3}, {1'b1, 1'b0, 3'd4});
    for (int n = 0; n < 1000; n++) begin
      applyStimulusNarrow(1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
